// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared widths and state/client encodings for the two-client
// DDR3 arbiter (ddr_arb2) and its burst tracker.
package ddr_arb_pkg;

    localparam int unsigned DDR_ADDR_W  = 32;
    localparam int unsigned DDR_DATA_W  = 64;
    localparam int unsigned DDR_BURST_W = 8;
    localparam int unsigned DDR_CNT_W   = 9;

    typedef enum logic [2:0] {
        IDLE,
        OWN_A,
        OWN_B,
        DRAIN_A,
        DRAIN_B
    } arb_state_t;

    typedef enum logic {
        CLI_A,
        CLI_B
    } client_t;

endpackage

// File: rtl/ddr_burst_tracker.sv
// ddr_burst_tracker: counts read beats still owed to the current owner and
// write beats still to be sent in the open write burst.
//   clk, reset_n     : clock, synchronous active-low reset
//   rd_accept        : read command accepted by the host this cycle
//   wr_accept        : write beat accepted by the host this cycle
//   burstcnt         : burst length of the presented command (0 means 1)
//   rdata_ready      : host returned a read beat this cycle
//   rd_fits          : presented read burst fits without overflowing the counter
//   rd_nonzero       : at least one read beat is outstanding (beat is routable)
//   wr_active        : a write burst is open (wr_remaining != 0)
//   idle             : both counters will be zero after this cycle
module ddr_burst_tracker
    import ddr_arb_pkg::*;
#(
    parameter int unsigned BURST_W = DDR_BURST_W,
    parameter int unsigned CNT_W   = DDR_CNT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               rd_accept,
    input  logic               wr_accept,
    input  logic [BURST_W-1:0] burstcnt,
    input  logic               rdata_ready,
    output logic               rd_fits,
    output logic               rd_nonzero,
    output logic               wr_active,
    output logic               idle
);

    // Two spare bits so the add-then-compare never wraps.
    localparam int unsigned SUM_W = ((CNT_W > BURST_W) ? CNT_W : BURST_W) + 2;
    localparam logic [SUM_W-1:0] RD_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [CNT_W-1:0]   rd_outstanding;
    logic [CNT_W-1:0]   rd_next;
    logic [BURST_W-1:0] wr_remaining;
    logic [BURST_W-1:0] wr_next;
    logic [BURST_W-1:0] beats;
    logic [SUM_W-1:0]   rd_sum;
    logic               rd_dec;

    always_comb begin
        beats      = (burstcnt == '0) ? BURST_W'(1) : burstcnt;
        // A beat arriving with nothing outstanding is stale and ignored.
        rd_dec     = rdata_ready && (rd_outstanding != '0);
        rd_sum     = SUM_W'(rd_outstanding) + SUM_W'(beats) - SUM_W'(rd_dec);
        rd_fits    = (rd_sum <= RD_MAX);

        rd_next = rd_outstanding;
        if (rd_accept) begin
            rd_next = rd_sum[CNT_W-1:0];
        end else if (rd_dec) begin
            rd_next = rd_outstanding - CNT_W'(1);
        end

        wr_next = wr_remaining;
        if (wr_accept) begin
            wr_next = (wr_remaining == '0) ? (beats - BURST_W'(1))
                                           : (wr_remaining - BURST_W'(1));
        end

        rd_nonzero = (rd_outstanding != '0);
        wr_active  = (wr_remaining != '0);
        // Looks one cycle ahead so the grant can drop in the same cycle the
        // last beat completes.
        idle       = (rd_next == '0) && (wr_next == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_outstanding <= '0;
            wr_remaining   <= '0;
        end else begin
            rd_outstanding <= rd_next;
            wr_remaining   <= wr_next;
        end
    end

endmodule

// File: rtl/ddr_arb2.sv
// ddr_arb2: two-client DDR3 arbiter with grant locking. Grants client A or B
// one at a time, holds the grant while that client keeps acquire high, then
// drains all its outstanding read/write beats before releasing. Round-robin
// when both request.
//   clk, reset_n           : clock, synchronous active-low reset
//   a_*/b_* (in)           : client acquire, addr, wdata, byteenable,
//                            burstcnt, read, write
//   a_busy/b_busy          : command not accepted this cycle
//   a_rdata/b_rdata        : host read data (broadcast)
//   a_/b_rdata_ready       : read beat valid for that client
//   x_* (out)              : host command (addr, wdata, byteenable, burstcnt,
//                            read, write)
//   x_busy, x_rdata, x_rdata_ready : host waitrequest and read return
module ddr_arb2
    import ddr_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DDR_ADDR_W,
    parameter int unsigned DATA_W  = DDR_DATA_W,
    parameter int unsigned BURST_W = DDR_BURST_W,
    parameter int unsigned CNT_W   = DDR_CNT_W
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                a_acquire,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    input  logic [DATA_W/8-1:0] a_byteenable,
    input  logic [BURST_W-1:0]  a_burstcnt,
    input  logic                a_read,
    input  logic                a_write,
    output logic                a_busy,
    output logic [DATA_W-1:0]   a_rdata,
    output logic                a_rdata_ready,

    input  logic                b_acquire,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wdata,
    input  logic [DATA_W/8-1:0] b_byteenable,
    input  logic [BURST_W-1:0]  b_burstcnt,
    input  logic                b_read,
    input  logic                b_write,
    output logic                b_busy,
    output logic [DATA_W-1:0]   b_rdata,
    output logic                b_rdata_ready,

    output logic [ADDR_W-1:0]   x_addr,
    output logic [DATA_W-1:0]   x_wdata,
    output logic [DATA_W/8-1:0] x_byteenable,
    output logic [BURST_W-1:0]  x_burstcnt,
    output logic                x_read,
    output logic                x_write,
    input  logic                x_busy,
    input  logic [DATA_W-1:0]   x_rdata,
    input  logic                x_rdata_ready
);

    arb_state_t state;
    client_t    last;

    logic sel_a;
    logic sel_b;
    logic own_cmd;
    logic in_drain;
    logic fwd;
    logic wr_path;
    logic cmd_read;
    logic cmd_write;
    logic owner_busy;
    logic rd_deliver;

    logic rd_fits;
    logic rd_nonzero;
    logic wr_active;
    logic drained;

    ddr_burst_tracker #(
        .BURST_W (BURST_W),
        .CNT_W   (CNT_W)
    ) u_tracker (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_accept   (x_read && !x_busy),
        .wr_accept   (x_write && !x_busy),
        .burstcnt    (x_burstcnt),
        .rdata_ready (x_rdata_ready),
        .rd_fits     (rd_fits),
        .rd_nonzero  (rd_nonzero),
        .wr_active   (wr_active),
        .idle        (drained)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            last  <= CLI_B;
        end else begin
            case (state)
                IDLE: begin
                    if (a_acquire && b_acquire) begin
                        if (last == CLI_B) begin
                            state <= OWN_A;
                            last  <= CLI_A;
                        end else begin
                            state <= OWN_B;
                            last  <= CLI_B;
                        end
                    end else if (a_acquire) begin
                        state <= OWN_A;
                        last  <= CLI_A;
                    end else if (b_acquire) begin
                        state <= OWN_B;
                        last  <= CLI_B;
                    end
                end
                OWN_A:   if (!a_acquire) state <= drained ? IDLE : DRAIN_A;
                OWN_B:   if (!b_acquire) state <= drained ? IDLE : DRAIN_B;
                DRAIN_A: if (drained)    state <= IDLE;
                DRAIN_B: if (drained)    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        sel_a    = (state == OWN_A) || (state == DRAIN_A);
        sel_b    = (state == OWN_B) || (state == DRAIN_B);
        own_cmd  = (state == OWN_A) || (state == OWN_B);
        in_drain = (state == DRAIN_A) || (state == DRAIN_B);

        x_addr       = sel_b ? b_addr       : a_addr;
        x_wdata      = sel_b ? b_wdata      : a_wdata;
        x_byteenable = sel_b ? b_byteenable : a_byteenable;
        x_burstcnt   = sel_b ? b_burstcnt   : a_burstcnt;
        cmd_read     = sel_b ? b_read       : a_read;
        cmd_write    = sel_b ? b_write      : a_write;

        fwd     = reset_n && own_cmd;
        // An open write burst keeps flowing while draining so wr_remaining
        // can reach zero; the client's busy then follows the host.
        wr_path = reset_n && (own_cmd || (in_drain && wr_active));

        x_read  = fwd && cmd_read && rd_fits;
        x_write = wr_path && cmd_write;

        owner_busy = x_busy || !wr_path || (cmd_read && !(fwd && rd_fits));
        a_busy     = sel_a ? owner_busy : 1'b1;
        b_busy     = sel_b ? owner_busy : 1'b1;

        rd_deliver    = reset_n && x_rdata_ready && rd_nonzero;
        a_rdata_ready = rd_deliver && sel_a;
        b_rdata_ready = rd_deliver && sel_b;
        a_rdata       = x_rdata;
        b_rdata       = x_rdata;
    end

endmodule

// File: tb/tb_ddr_arb2.sv
// tb_ddr_arb2: directed self-checking bench for ddr_arb2. Inputs are driven
// 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_ddr_arb2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_acquire, b_acquire;
    logic [31:0] a_addr, b_addr;
    logic [63:0] a_wdata, b_wdata;
    logic [7:0]  a_byteenable, b_byteenable;
    logic [7:0]  a_burstcnt, b_burstcnt;
    logic        a_read, b_read, a_write, b_write;
    logic        a_busy, b_busy;
    logic [63:0] a_rdata, b_rdata;
    logic        a_rdata_ready, b_rdata_ready;
    logic [31:0] x_addr;
    logic [63:0] x_wdata;
    logic [7:0]  x_byteenable;
    logic [7:0]  x_burstcnt;
    logic        x_read, x_write;
    logic        x_busy;
    logic [63:0] x_rdata;
    logic        x_rdata_ready;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    ddr_arb2 #(
        .ADDR_W  (32),
        .DATA_W  (64),
        .BURST_W (8),
        .CNT_W   (9)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .a_acquire     (a_acquire),
        .a_addr        (a_addr),
        .a_wdata       (a_wdata),
        .a_byteenable  (a_byteenable),
        .a_burstcnt    (a_burstcnt),
        .a_read        (a_read),
        .a_write       (a_write),
        .a_busy        (a_busy),
        .a_rdata       (a_rdata),
        .a_rdata_ready (a_rdata_ready),
        .b_acquire     (b_acquire),
        .b_addr        (b_addr),
        .b_wdata       (b_wdata),
        .b_byteenable  (b_byteenable),
        .b_burstcnt    (b_burstcnt),
        .b_read        (b_read),
        .b_write       (b_write),
        .b_busy        (b_busy),
        .b_rdata       (b_rdata),
        .b_rdata_ready (b_rdata_ready),
        .x_addr        (x_addr),
        .x_wdata       (x_wdata),
        .x_byteenable  (x_byteenable),
        .x_burstcnt    (x_burstcnt),
        .x_read        (x_read),
        .x_write       (x_write),
        .x_busy        (x_busy),
        .x_rdata       (x_rdata),
        .x_rdata_ready (x_rdata_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        a_acquire = 1'b0; b_acquire = 1'b0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        a_byteenable = '0; b_byteenable = '0; a_burstcnt = '0; b_burstcnt = '0;
        a_read = 1'b0; b_read = 1'b0; a_write = 1'b0; b_write = 1'b0;
        x_busy = 1'b0; x_rdata = '0; x_rdata_ready = 1'b0;

        // Reset cycle: commands and read beats blocked.
        a_acquire = 1'b1; a_read = 1'b1; a_burstcnt = 8'd4; x_rdata_ready = 1'b1;
        #1;
        chk("rst_x_read", x_read, 0);
        chk("rst_a_busy", a_busy, 1);
        chk("rst_b_busy", b_busy, 1);
        chk("rst_a_rdy", a_rdata_ready, 0);
        tick(); tick();

        // Grant A, read burst of 4.
        a_read = 1'b0; x_rdata_ready = 1'b0; reset_n = 1'b1;
        #1;
        chk("idle_a_busy", a_busy, 1);
        tick();
        chk("ownA_a_busy", a_busy, 0);
        chk("ownA_b_busy", b_busy, 1);
        a_read = 1'b1; a_addr = 32'h1000; a_burstcnt = 8'd4;
        #1;
        chk("t1_x_read", x_read, 1);
        chk("t1_x_addr", x_addr, 32'h1000);
        chk("t1_x_burst", x_burstcnt, 4);
        tick();
        a_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x_rdata_ready = 1'b1; x_rdata = 64'hA000 + 64'(i);
            #1;
            chk("t1_a_rdy", a_rdata_ready, 1);
            chk("t1_b_rdy", b_rdata_ready, 0);
            chk("t1_a_rdata", a_rdata, 64'hA000 + 64'(i));
            tick();
        end
        x_rdata_ready = 1'b1;
        #1;
        chk("t1_underflow", a_rdata_ready, 0);
        x_rdata_ready = 1'b0;
        a_acquire = 1'b0;
        tick();
        chk("t1_release", a_busy, 1);

        // Both request after reset: A wins, then B.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; a_acquire = 1'b1; b_acquire = 1'b1;
        tick();
        chk("t2_a_first", a_busy, 0);
        chk("t2_b_wait", b_busy, 1);
        a_acquire = 1'b0;
        tick();
        chk("t2_idle_a", a_busy, 1);
        chk("t2_idle_b", b_busy, 1);
        tick();
        chk("t2_b_grant", b_busy, 0);
        chk("t2_a_block", a_busy, 1);
        b_read = 1'b1; b_addr = 32'h2000; b_burstcnt = 8'd0;
        #1;
        chk("t2_x_addr", x_addr, 32'h2000);
        chk("t2_x_read", x_read, 1);
        tick();
        b_read = 1'b0; x_rdata_ready = 1'b1;
        #1;
        chk("t2_b_rdy", b_rdata_ready, 1);
        chk("t2_a_rdy", a_rdata_ready, 0);
        tick();
        #1;
        chk("t2_burst0_one", b_rdata_ready, 0);
        x_rdata_ready = 1'b0; b_acquire = 1'b0;
        tick();
        chk("t2_b_release", b_busy, 1);

        // Read burst 8, acquire drops after 3 beats, drain the rest.
        a_acquire = 1'b1; b_acquire = 1'b1;
        tick();
        chk("t3_rr_a", a_busy, 0);
        a_read = 1'b1; a_addr = 32'h3000; a_burstcnt = 8'd8;
        #1;
        chk("t3_x_read", x_read, 1);
        tick();
        a_read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            x_rdata_ready = 1'b1;
            #1;
            chk("t3_beat", a_rdata_ready, 1);
            tick();
        end
        x_rdata_ready = 1'b0; a_acquire = 1'b0;
        tick();
        a_read = 1'b1;
        #1;
        chk("t3_drain_xrd", x_read, 0);
        chk("t3_drain_abusy", a_busy, 1);
        chk("t3_drain_bbusy", b_busy, 1);
        a_read = 1'b0; a_acquire = 1'b1;
        for (int i = 0; i < 5; i++) begin
            x_rdata_ready = 1'b1;
            #1;
            chk("t3_drain_beat", a_rdata_ready, 1);
            chk("t3_drain_brdy", b_rdata_ready, 0);
            chk("t3_drain_bwait", b_busy, 1);
            tick();
        end
        x_rdata_ready = 1'b0;
        #1;
        chk("t3_idle_b", b_busy, 1);
        chk("t3_idle_a", a_busy, 1);
        tick();
        chk("t3_rr_b", b_busy, 0);
        chk("t3_rr_a_wait", a_busy, 1);
        a_acquire = 1'b0; b_acquire = 1'b0;
        tick();

        // Write burst 3 with host stall on beat 2, acquire dropped mid-burst.
        a_acquire = 1'b1;
        tick();
        a_write = 1'b1; a_burstcnt = 8'd3; a_wdata = 64'h1111; a_byteenable = 8'hff;
        #1;
        chk("t4_x_write", x_write, 1);
        chk("t4_x_wdata", x_wdata, 64'h1111);
        chk("t4_x_be", x_byteenable, 8'hff);
        chk("t4_busy0", a_busy, 0);
        tick();
        a_wdata = 64'h2222; x_busy = 1'b1;
        #1;
        chk("t4_stall1", a_busy, 1);
        chk("t4_stall_xw", x_write, 1);
        tick();
        chk("t4_stall2", a_busy, 1);
        x_busy = 1'b0;
        #1;
        chk("t4_unstall", a_busy, 0);
        tick();
        a_write = 1'b0; a_acquire = 1'b0; b_acquire = 1'b1;
        tick();
        chk("t4_held1", b_busy, 1);
        tick();
        chk("t4_held2", b_busy, 1);
        a_write = 1'b1; a_wdata = 64'h3333;
        #1;
        chk("t4_drain_xw", x_write, 1);
        chk("t4_drain_wd", x_wdata, 64'h3333);
        tick();
        a_write = 1'b0;
        #1;
        chk("t4_idle_b", b_busy, 1);
        tick();
        chk("t4_b_grant", b_busy, 0);
        b_acquire = 1'b0;
        tick();

        // Read accept and read return in the same cycle: 2 + 4 - 1 = 5.
        a_acquire = 1'b1;
        tick();
        a_read = 1'b1; a_burstcnt = 8'd2;
        tick();
        a_burstcnt = 8'd4; x_rdata_ready = 1'b1;
        #1;
        chk("t5_x_read", x_read, 1);
        chk("t5_a_rdy", a_rdata_ready, 1);
        tick();
        a_read = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_beat", a_rdata_ready, 1);
            tick();
        end
        #1;
        chk("t5_extra", a_rdata_ready, 0);
        x_rdata_ready = 1'b0;

        // Counter saturation at 511.
        a_read = 1'b1; a_burstcnt = 8'd255;
        tick(); tick();
        chk("sat_hold_xrd", x_read, 0);
        chk("sat_hold_busy", a_busy, 1);
        a_burstcnt = 8'd1;
        #1;
        chk("sat_fit_xrd", x_read, 1);
        chk("sat_fit_busy", a_busy, 0);
        tick();
        chk("sat_full_xrd", x_read, 0);
        chk("sat_full_busy", a_busy, 1);
        a_read = 1'b0;

        // Reset in the middle of a read burst of 6.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        a_read = 1'b1; a_burstcnt = 8'd6;
        tick();
        a_read = 1'b0; reset_n = 1'b0; x_rdata_ready = 1'b1;
        #1;
        chk("t6_rst_rdy", a_rdata_ready, 0);
        chk("t6_rst_abusy", a_busy, 1);
        chk("t6_rst_bbusy", b_busy, 1);
        tick();
        reset_n = 1'b1; a_acquire = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t6_drop_a", a_rdata_ready, 0);
            chk("t6_drop_b", b_rdata_ready, 0);
            tick();
        end
        a_acquire = 1'b1;
        tick();
        chk("t6_regrant", a_busy, 0);
        chk("t6_cnt_zero", a_rdata_ready, 0);
        x_rdata_ready = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
